// File: rtl/ex_muldiv_seq.sv
// Iterative 32-cycle multiply/divide unit beside the EX stage; owns HI/LO and
// stalls the pipeline while an operation is in flight.
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] readRs,
  input  logic [31:0] readRt,
  input  logic        read_hilo,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  logic [5:0]  count;
  logic        is_div;
  logic        neg_res;
  logic        rem_neg;
  logic        dz;
  logic [31:0] opnd;
  logic [31:0] raw_a;
  logic [63:0] prod;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] trial, sub;
  logic [63:0] div_next;
  logic [63:0] prod_neg;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    a_neg = op[0] & readRs[31];
    b_neg = op[0] & readRt[31];
    a_mag = a_neg ? (~readRs + 32'd1) : readRs;
    b_mag = b_neg ? (~readRt + 32'd1) : readRt;
  end

  // Shift-add: multiplier sits in prod[31:0] and is consumed LSB first.
  always_comb begin
    mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, prod[31:1]};
  end

  // Restoring divide: remainder in prod[63:32], dividend/quotient in prod[31:0].
  // Since remainder < divisor, sub[32] is set exactly when the trial underflows.
  always_comb begin
    trial    = {prod[63:32], prod[31]};
    sub      = trial - {1'b0, opnd};
    div_next = sub[32] ? {prod[62:0], 1'b0} : {sub[31:0], prod[30:0], 1'b1};
  end

  always_comb begin
    prod_neg = ~prod + 64'd1;
    res_hi   = prod[63:32];
    res_lo   = prod[31:0];
    if (!is_div) begin
      if (neg_res) {res_hi, res_lo} = prod_neg;
    end else if (dz) begin
      res_hi = raw_a;
      res_lo = '1;
    end else begin
      if (neg_res) res_lo = prod_neg[31:0];
      if (rem_neg) res_hi = ~prod[63:32] + 32'd1;
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (read_hilo | start | wr_hi | wr_lo);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      rem_neg  <= 1'b0;
      dz       <= 1'b0;
      opnd     <= '0;
      raw_a    <= '0;
      prod     <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div   <= op[1];
            neg_res  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            dz       <= op[1] & (readRt == '0);
            raw_a    <= readRs;
            opnd     <= op[1] ? b_mag : a_mag;
            prod     <= op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
            count    <= '0;
            div_zero <= 1'b0;
            state    <= RUN;
          end else begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            prod  <= is_div ? div_next : mul_next;
            count <= count + 6'd1;
            if (count == 6'd31) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
            if (dz) div_zero <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: vector table plus stall/flush/reset sequences.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] readRs = '0;
  logic [31:0] readRt = '0;
  logic        read_hilo = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall, done, div_zero;

  int checks = 0;
  int errors = 0;

  ex_muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .readRs(readRs),
    .readRt(readRt), .read_hilo(read_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdata(wdata), .flush(flush), .hi(hi), .lo(lo), .busy(busy),
    .stall(stall), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op and returns at the negedge of the done cycle (or after a bound).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; op = o; readRs = a; readRt = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcyc = 0;
    while (!done && lat < 100) begin
      if (busy) bcyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  int lat, bcyc, mism, n;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
    vecs[5]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[6]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0};
    vecs[9]  = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[11] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    chk("rst_dz", {31'd0, div_zero}, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'h0);

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcyc);
      chk($sformatf("v%0d_lat", i), lat, 33);
      chk($sformatf("v%0d_busycyc", i), bcyc, 33);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'h0);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dz", i), {31'd0, div_zero}, {31'd0, vecs[i].dz});
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'h0);
    end

    // MTLO / MTHI in IDLE
    wr_lo = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo", lo, 32'hAAAA5555);
    wr_hi = 1'b1; wdata = 32'h13572468;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi", hi, 32'h13572468);

    // read_hilo held from cycle 5; an MTLO while busy must be dropped
    @(negedge clk);
    start = 1'b1; op = 2'b00; readRs = 32'd5; readRt = 32'd6;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    read_hilo = 1'b1; wr_lo = 1'b1; wdata = 32'hDEADBEEF;
    #1;
    chk("stall_rd", {31'd0, stall}, 32'h1);
    @(negedge clk);
    wr_lo = 1'b0;
    mism = 0; n = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1) mism++;
      @(negedge clk);
      n++;
    end
    chk("stall_track", mism, 0);
    chk("stall_bound", {31'd0, busy}, 32'h0);
    chk("stall_release", {31'd0, stall}, 32'h0);
    chk("stall_done", {31'd0, done}, 32'h1);
    chk("stall_hi", hi, 32'h0);
    chk("stall_lo", lo, 32'h0000001E);
    read_hilo = 1'b0;

    // flush mid-RUN keeps prior HI/LO
    @(negedge clk);
    wr_hi = 1'b1; wdata = 32'd1;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'd2;
    @(negedge clk);
    wr_lo = 1'b0;
    start = 1'b1; op = 2'b00; readRs = 32'hFFFFFFFF; readRt = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'h0);
    chk("flush_hi", hi, 32'd1);
    chk("flush_lo", lo, 32'd2);
    chk("flush_done", {31'd0, done}, 32'h0);
    do_op(2'b00, 32'd3, 32'd4, lat, bcyc);
    chk("post_flush_lat", lat, 33);
    chk("post_flush_hi", hi, 32'h0);
    chk("post_flush_lo", lo, 32'hC);

    // reset mid-RUN
    @(negedge clk);
    start = 1'b1; op = 2'b01; readRs = 32'd5; readRt = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    read_hilo = 1'b1;
    reset = 1'b0;
    #1;
    chk("rrst_busy", {31'd0, busy}, 32'h0);
    chk("rrst_stall", {31'd0, stall}, 32'h0);
    chk("rrst_hi", hi, 32'h0);
    chk("rrst_lo", lo, 32'h0);
    chk("rrst_done", {31'd0, done}, 32'h0);
    chk("rrst_dz", {31'd0, div_zero}, 32'h0);
    @(negedge clk);
    reset = 1'b1; read_hilo = 1'b0;
    do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
    chk("ovf_lat", lat, 33);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_dz", {31'd0, div_zero}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
